// File: rtl/reg_writeback.sv
// reg_writeback: in-order writeback queue that arbitrates ALU and load results
// and drains one register-file write per cycle.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [WIDTH-1:0]         alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [WIDTH-1:0]         mem_data,
  input  logic                     hold,
  output logic                     we,
  output logic [4:0]               rw,
  output logic [WIDTH-1:0]         Din,
  output logic [31:0]              busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL = CW'(DEPTH);
  logic [4:0]       rd_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             last_mem, space, grant_mem, grant_alu, accept, push;
  logic [4:0]       push_rd;
  logic [WIDTH-1:0] push_data;
  assign we        = reset_n & (count != '0) & ~hold;
  assign rw        = we ? rd_q[rd_ptr] : '0;
  assign Din       = we ? data_q[rd_ptr] : '0;
  assign space     = (count < FULL) | we;
  // round-robin: on contention the producer not served last wins
  assign grant_mem = mem_valid & (~alu_valid | ~last_mem);
  assign grant_alu = alu_valid & ~grant_mem;
  assign mem_ready = reset_n & space & grant_mem;
  assign alu_ready = reset_n & space & grant_alu;
  assign accept    = alu_ready | mem_ready;
  assign push_rd   = mem_ready ? mem_rd : alu_rd;
  assign push_data = mem_ready ? mem_data : alu_data;
  assign push      = accept & (push_rd != '0);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_mem <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr + AW'(we);
      wr_ptr   <= wr_ptr + AW'(push);
      count    <= count + CW'(push) - CW'(we);
      last_mem <= accept ? mem_ready : last_mem;
    end
  always_ff @(posedge clk)
    if (push) begin
      rd_q[wr_ptr]   <= push_rd;
      data_q[wr_ptr] <= push_data;
    end
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count) busy[rd_q[rd_ptr + AW'(i)]] = 1'b1;
    busy[0] = 1'b0;
  end
endmodule
